puf_chal_verifier: RTL and testbench

PUF_CHAL_VERIFIER -- requirements
Module: puf_chal_verifier

---
 rtl/puf_verifier_pkg.sv | 16 +
 rtl/puf_popcount16.sv | 16 +
 rtl/puf_chal_verifier.sv | 182 ++++++++++++++++++
 tb/tb_puf_chal_verifier.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_verifier_pkg.sv
// Shared types and widths for the RO-PUF challenge/response verifier.
package puf_verifier_pkg;

    localparam int unsigned CHAL_W = 4;
    localparam int unsigned RESP_W = 16;
    localparam int unsigned HD_W   = 5;
    localparam int unsigned HDT_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StEval,
        StDone
    } state_e;

endpackage

// File: rtl/puf_popcount16.sv
// Combinational Hamming weight of a 16-bit word.
module puf_popcount16
    import puf_verifier_pkg::*;
(
    input  logic [RESP_W-1:0] data,
    output logic [HD_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < RESP_W; i++) begin
            count = count + HD_W'(data[i]);
        end
    end

endmodule

// File: rtl/puf_chal_verifier.sv
// Enrolls and verifies RO-PUF responses against an internal 16-entry table.
// Optional ack timeout enabled by defining PUF_VERIFIER_TIMEOUT_EN.
module puf_chal_verifier
    import puf_verifier_pkg::*;
#(
    parameter int unsigned NUM_CHAL    = 4,
    parameter int unsigned HD_THRESH   = 3,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              enroll,
    input  logic [CHAL_W-1:0] chal_base,
    output logic              puf_req,
    output logic [CHAL_W-1:0] puf_chal,
    input  logic              puf_ack,
    input  logic [RESP_W-1:0] puf_resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_timeout,
    output logic [HDT_W-1:0]  hd_total
);

    localparam logic [CHAL_W-1:0] LastIdx = CHAL_W'(NUM_CHAL - 1);
    localparam logic [HD_W-1:0]   HdThr   = HD_W'(HD_THRESH);

    state_e              state_q, state_d;
    logic                enroll_q, enroll_d;
    logic [CHAL_W-1:0]   base_q, base_d;
    logic [CHAL_W-1:0]   idx_q, idx_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [HDT_W-1:0]    hd_total_q, hd_total_d;
    logic                fail_q, fail_d;
    logic                pass_q, pass_d;
    logic [15:0]         valid_q, valid_d;
    logic [RESP_W-1:0]   table_q [16];

    logic [HD_W-1:0]     hd;
    logic [HDT_W:0]      hd_sum;
    logic [HDT_W-1:0]    hd_sat;
    logic                tmo_hit;

    assign puf_chal = base_q + idx_q;

    puf_popcount16 u_popcount (
        .data  (resp_q ^ table_q[puf_chal]),
        .count (hd)
    );

    assign hd_sum = {1'b0, hd_total_q} + (HDT_W + 1)'(hd);
    assign hd_sat = hd_sum[HDT_W] ? '1 : hd_sum[HDT_W-1:0];

`ifdef PUF_VERIFIER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            err_q;

    // Counter restarts on every ISSUE entry; an ack in the expiry cycle still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == StIssue && !puf_ack) begin
                tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
            if (state_q == StIdle && start) begin
                err_q <= 1'b0;
            end else if (state_q == StIssue && !puf_ack && tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign tmo_hit     = (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
    assign err_timeout = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        enroll_d   = enroll_q;
        base_d     = base_q;
        idx_d      = idx_q;
        resp_d     = resp_q;
        hd_total_d = hd_total_q;
        fail_d     = fail_q;
        pass_d     = pass_q;
        valid_d    = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StIssue;
                    enroll_d   = enroll;
                    base_d     = chal_base;
                    idx_d      = '0;
                    hd_total_d = '0;
                    fail_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            StIssue: begin
                if (puf_ack) begin
                    resp_d  = puf_resp;
                    state_d = StEval;
                end else if (tmo_hit) begin
                    state_d = StDone;
                end
            end
            StEval: begin
                if (enroll_q) begin
                    valid_d[puf_chal] = 1'b1;
                end else begin
                    hd_total_d = hd_sat;
                    if (hd > HdThr || !valid_q[puf_chal]) begin
                        fail_d = 1'b1;
                    end
                end
                if (idx_q != LastIdx) begin
                    idx_d   = idx_q + CHAL_W'(1);
                    state_d = StIssue;
                end else begin
                    state_d = StDone;
                    pass_d  = !enroll_q && !fail_d;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            enroll_q   <= 1'b0;
            base_q     <= '0;
            idx_q      <= '0;
            resp_q     <= '0;
            hd_total_q <= '0;
            fail_q     <= 1'b0;
            pass_q     <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            enroll_q   <= enroll_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            resp_q     <= resp_d;
            hd_total_q <= hd_total_d;
            fail_q     <= fail_d;
            pass_q     <= pass_d;
            valid_q    <= valid_d;
        end
    end

    // Table contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (state_q == StEval && enroll_q) begin
            table_q[puf_chal] <= resp_q;
        end
    end

    assign puf_req  = (state_q == StIssue);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign pass     = pass_q;
    assign hd_total = hd_total_q;

endmodule

// File: tb/tb_puf_chal_verifier.sv
// Table-driven bench for puf_chal_verifier; timeout case built with PUF_VERIFIER_TIMEOUT_EN.
module tb_puf_chal_verifier;

    localparam int unsigned NumChal = 4;
    localparam int unsigned HdThresh = 3;
    localparam int unsigned TimeoutCyc = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        enroll = 1'b0;
    logic [3:0]  chal_base = 4'h0;
    logic        puf_req;
    logic [3:0]  puf_chal;
    logic        puf_ack = 1'b0;
    logic [15:0] puf_resp = 16'h0;
    logic        busy;
    logic        done;
    logic        pass;
    logic        err_timeout;
    logic [7:0]  hd_total;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    puf_chal_verifier #(
        .NUM_CHAL    (NumChal),
        .HD_THRESH   (HdThresh),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .enroll      (enroll),
        .chal_base   (chal_base),
        .puf_req     (puf_req),
        .puf_chal    (puf_chal),
        .puf_ack     (puf_ack),
        .puf_resp    (puf_resp),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_timeout (err_timeout),
        .hd_total    (hd_total)
    );

    typedef struct packed {
        logic            enroll;
        logic [3:0]      base;
        logic [3:0][15:0] resp;
        logic            dbl_ack;
        logic            bstart;
        logic            exp_pass;
        logic            chk_hd;
        logic [7:0]      exp_hd;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic en, input logic [3:0] base,
                                input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3,
                                input logic dbl, input logic bs, input logic ep,
                                input logic ch, input logic [7:0] eh);
        vec_t v;
        v.enroll = en;
        v.base = base;
        v.resp[0] = r0;
        v.resp[1] = r1;
        v.resp[2] = r2;
        v.resp[3] = r3;
        v.dbl_ack = dbl;
        v.bstart = bs;
        v.exp_pass = ep;
        v.chk_hd = ch;
        v.exp_hd = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int n;
        logic [3:0] ec;
        start = 1'b1;
        enroll = v.enroll;
        chal_base = v.base;
        tick();
        start = 1'b0;
        enroll = 1'b0;
        chal_base = 4'hf;
        chk($sformatf("v%0d_busy", id), 32'(busy), 32'd1);
        for (int k = 0; k < int'(NumChal); k++) begin
            n = 0;
            while (!puf_req && n < 20) begin
                tick();
                n++;
            end
            ec = v.base + 4'(k);
            chk($sformatf("v%0d_req%0d", id, k), 32'(puf_req), 32'd1);
            chk($sformatf("v%0d_chal%0d", id, k), 32'(puf_chal), 32'(ec));
            if (v.bstart && k == 1) begin
                start = 1'b1;
                enroll = ~v.enroll;
                chal_base = v.base + 4'd7;
            end
            tick();
            start = 1'b0;
            enroll = 1'b0;
            chal_base = 4'hf;
            chk($sformatf("v%0d_hold%0d", id, k), 32'({puf_req, puf_chal}), 32'({1'b1, ec}));
            puf_ack = 1'b1;
            puf_resp = v.resp[k];
            tick();
            chk($sformatf("v%0d_reqdrop%0d", id, k), 32'(puf_req), 32'd0);
            // Ack left high into EVAL with a bogus response must be ignored.
            if (v.dbl_ack) begin
                puf_resp = 16'hffff;
                tick();
            end
            puf_ack = 1'b0;
        end
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("v%0d_done_lat", id), 32'(n), v.dbl_ack ? 32'd0 : 32'd1);
        chk($sformatf("v%0d_pass", id), 32'(pass), 32'(v.exp_pass));
        chk($sformatf("v%0d_err", id), 32'(err_timeout), 32'd0);
        if (v.chk_hd) chk($sformatf("v%0d_hd", id), 32'(hd_total), 32'(v.exp_hd));
        tick();
        chk($sformatf("v%0d_done_pulse", id), 32'({done, busy}), 32'd0);
        chk($sformatf("v%0d_pass_held", id), 32'(pass), 32'(v.exp_pass));
    endtask

    initial begin
        int n;
        // 0x1234^0xE234 = 0xF000 (hd 4); 0x1234^0x1233 = 0x0007 (hd 3, at threshold).
        vecs[0] = mk(1'b1, 4'd2, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 0, 0, 0, 1, 8'd0);
        vecs[1] = mk(1'b0, 4'd2, 16'h1235, 16'h1234, 16'h1234, 16'h1234, 1, 0, 1, 1, 8'd1);
        vecs[2] = mk(1'b0, 4'd2, 16'h1234, 16'hE234, 16'h1234, 16'h1234, 0, 0, 0, 1, 8'd4);
        vecs[3] = mk(1'b0, 4'd2, 16'h1233, 16'h1234, 16'h1234, 16'h1234, 0, 0, 1, 1, 8'd3);
        vecs[4] = mk(1'b1, 4'd14, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 0, 0, 0, 1, 8'd0);
        vecs[5] = mk(1'b0, 4'd14, 16'hAAAB, 16'hAAAA, 16'hAAA8, 16'hAAAA, 1, 0, 1, 1, 8'd2);
        vecs[6] = mk(1'b0, 4'd0, 16'hAAAA, 16'hAAAA, 16'h1234, 16'h1234, 0, 0, 1, 1, 8'd0);
        vecs[7] = mk(1'b0, 4'd4, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 0, 0, 0, 0, 8'd0);
        vecs[8] = mk(1'b0, 4'd2, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 0, 1, 1, 1, 8'd0);
        // Post-reset: valid bits cleared but table contents retained.
        vecs[9] = mk(1'b0, 4'd14, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 0, 0, 0, 1, 8'd0);
        vecs[10] = mk(1'b0, 4'd2, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 0, 0, 0, 1, 8'd0);

        #1;
        chk("rst_outputs", 32'({puf_req, busy, done, pass, err_timeout}), 32'd0);
        chk("rst_hd_chal", 32'({hd_total, puf_chal}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in the middle of ISSUE aborts with no done pulse.
        start = 1'b1;
        enroll = 1'b1;
        chal_base = 4'd2;
        tick();
        start = 1'b0;
        enroll = 1'b0;
        tick();
        chk("mid_req", 32'(puf_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_busy", 32'({puf_req, busy}), 32'd0);
        chk("mid_rst_chal_hd", 32'({puf_chal, hd_total}), 32'd0);
        n = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) n++;
        end
        chk("mid_rst_no_done", 32'(n), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_idle", 32'({busy, done, pass}), 32'd0);

        run_vec(9, vecs[9]);
        run_vec(10, vecs[10]);

`ifdef PUF_VERIFIER_TIMEOUT_EN
        start = 1'b1;
        enroll = 1'b0;
        chal_base = 4'd2;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 1100) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TimeoutCyc + 1));
        chk("tmo_err_pass", 32'({err_timeout, pass}), 32'b10);
        tick();
        chk("tmo_err_held", 32'({err_timeout, done}), 32'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
